// File: rtl/led_bar_pkg.sv
// Shared types and helpers for the LED level bar: display/activity state,
// a constant clog2, and the magnitude-to-level quantiser.
package led_bar_pkg;

  typedef enum logic {
    DISPLAY  = 1'b0,
    ACTIVITY = 1'b1
  } state_e;

  // Bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Bar level k for a one's-complement magnitude: scale by LED count,
  // drop the sample fraction bits, clamp to the outermost LED.
  function automatic int level_k(input int mag, input int num_led, input int data_w);
    longint p;
    p = longint'(mag) * longint'(num_led);
    p = p >> (data_w - 1);
    if (p > longint'(num_led - 1)) p = longint'(num_led - 1);
    return int'(p);
  endfunction

endpackage

// File: rtl/led_level_bar_if.sv
// Sample, mode and activity inputs plus LED outputs of the level bar.
interface led_level_bar_if #(
  parameter int DATA_W  = 10,
  parameter int NUM_LED = 10
);
  logic signed [DATA_W-1:0] iDIG;
  logic                     iDIG_VALID;
  logic                     iRANGE;
  logic                     iMODE;
  logic                     iG_INT2;
  logic [NUM_LED-1:0]       oLED;
  logic                     oACTIVE;

  modport master (
    output iDIG, iDIG_VALID, iRANGE, iMODE, iG_INT2,
    input  oLED, oACTIVE
  );

  modport slave (
    input  iDIG, iDIG_VALID, iRANGE, iMODE, iG_INT2,
    output oLED, oACTIVE
  );
endinterface

// File: rtl/led_bar_encode.sv
// Turns a level k, sign and display mode into the LED pattern.
// Positive levels grow upward from the centre; negative ones are mirrored.
module led_bar_encode
  import led_bar_pkg::*;
#(
  parameter int NUM_LED = 10,
  parameter int KW      = 4
) (
  input  logic [KW-1:0]      k_i,
  input  logic               neg_i,
  input  logic               mode_i,
  output logic [NUM_LED-1:0] pat_o
);
  localparam int L = NUM_LED / 2;

  logic [NUM_LED-1:0] pos;
  int                 lo;
  int                 hi;

  // Build the positive-side lit range, then mirror it for negative samples
  always_comb begin
    hi = L + int'(k_i) / 2;
    if (mode_i) lo = (k_i == '0) ? L - 1 : L;
    else        lo = L - 1 + (int'(k_i) + 1) / 2;
    pos   = '0;
    pat_o = '0;
    for (int i = 0; i < NUM_LED; i++) pos[i] = (i >= lo) && (i <= hi);
    for (int i = 0; i < NUM_LED; i++) pat_o[i] = neg_i ? pos[NUM_LED-1-i] : pos[i];
  end

endmodule

// File: rtl/led_level_bar.sv
// Tilt/level bar driver: range-scales accelerometer samples, quantises them
// into a dot or bar pattern, and overrides the LEDs with a blinking activity
// display for ACT_CYCLES clocks after each iG_INT2 rising edge.
// Optional: define LED_SMOOTH_EN to insert a leaky-average filter in place
// of the plain sample register.
module led_level_bar
  import led_bar_pkg::*;
#(
  parameter int DATA_W       = 10,
  parameter int NUM_LED      = 10,
  parameter int ACT_CYCLES   = 8388608,
  parameter int BLINK_CYCLES = 1048576,
  parameter int AVG_SHIFT    = 2
) (
  input  logic            iCLK,
  input  logic            iRSTN,
  led_level_bar_if.slave  bus
);
  localparam int KW = clog2(NUM_LED);
  localparam int CW = clog2(ACT_CYCLES);

  // Reject parameter sets the quantiser and blink timer cannot represent
  if (NUM_LED < 4 || (NUM_LED % 2) != 0 || DATA_W < 4 ||
      AVG_SHIFT < 1 || AVG_SHIFT > 4 || ACT_CYCLES < 2 * BLINK_CYCLES) begin : g_bad_params
    $error("led_level_bar: illegal parameter combination");
  end

  logic                     sync1_q, sync2_q, prev_q;
  logic                     int_rise;
  logic signed [DATA_W-1:0] s_in;
  logic signed [DATA_W-1:0] level_s;
  logic [DATA_W-2:0]        mag;
  logic [KW-1:0]            k;
  logic [NUM_LED-1:0]       pat;
  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     blink_off;
  logic [NUM_LED-1:0]       led_q, led_d;
  logic                     active_q, active_d;

  // Two-flop synchroniser for the async interrupt plus a history flop for edge detect
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.iG_INT2;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign int_rise = sync2_q & ~prev_q;

  // Half-scale mode: saturate to DATA_W-1 bits, then apply x2 gain
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    s_in = bus.iDIG;
    if (!bus.iRANGE) begin
      if (bus.iDIG[DATA_W-1] != bus.iDIG[DATA_W-2])
        s_in = bus.iDIG[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-2){1'b1}}, 1'b0};
      else
        s_in = {bus.iDIG[DATA_W-2:0], 1'b0};
    end
  end

`ifdef LED_SMOOTH_EN
  localparam int AW = DATA_W + AVG_SHIFT;
  logic signed [AW-1:0] acc_q, acc_d;

  // Leaky integrator: acc settles at 2^AVG_SHIFT times the running mean
  always_comb begin
    acc_d = acc_q;
    if (bus.iDIG_VALID) acc_d = acc_q + AW'(s_in) - (acc_q >>> AVG_SHIFT);
  end

  // Filter state register
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign level_s = DATA_W'(acc_q >>> AVG_SHIFT);
`else
  logic signed [DATA_W-1:0] sample_q, sample_d;

  assign sample_d = bus.iDIG_VALID ? s_in : sample_q;

  // Sample register, loaded on each strobe
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) sample_q <= '0;
    else        sample_q <= sample_d;
  end

  assign level_s = sample_q;
`endif

  // One's-complement magnitude keeps -1 and 0 on the same centre pair
  assign mag = level_s[DATA_W-1] ? ~level_s[DATA_W-2:0] : level_s[DATA_W-2:0];
  assign k   = KW'(level_k(int'(mag), NUM_LED, DATA_W));

  led_bar_encode #(
    .NUM_LED (NUM_LED),
    .KW      (KW)
  ) u_encode (
    .k_i    (k),
    .neg_i  (level_s[DATA_W-1]),
    .mode_i (bus.iMODE),
    .pat_o  (pat)
  );

  // Activity timer: an edge (re)starts it, and wins over the terminal count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (int_rise) begin
      state_d = ACTIVITY;
      cnt_d   = '0;
    end else if (state_q == ACTIVITY) begin
      if (cnt_q == CW'(ACT_CYCLES - 1)) begin
        state_d = DISPLAY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Outputs are derived from next state so oACTIVE and the blink align with the state flop
  always_comb begin
    blink_off = |((cnt_d / CW'(BLINK_CYCLES)) & CW'(1));
    active_d  = (state_d == ACTIVITY);
    led_d     = pat;
    if (state_d == ACTIVITY) led_d = blink_off ? '0 : '1;
  end

  // State, counter and registered outputs
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q  <= DISPLAY;
      cnt_q    <= '0;
      led_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      active_q <= active_d;
    end
  end

  assign bus.oLED    = led_q;
  assign bus.oACTIVE = active_q;

endmodule

// File: tb/tb_led_level_bar.sv
// Self-checking bench for led_level_bar: directed and random samples against
// a rule-level model, activity blink/retrigger timing, and async reset.
module tb_led_level_bar;
  localparam int DATA_W    = 10;
  localparam int NUM_LED   = 10;
  localparam int ACT       = 64;
  localparam int BLINK     = 8;
  localparam int AVG_SHIFT = 2;
  localparam int L         = NUM_LED / 2;

  logic clk = 1'b0;
  logic rst_n;

  led_level_bar_if #(.DATA_W(DATA_W), .NUM_LED(NUM_LED)) bus ();

  led_level_bar #(
    .DATA_W       (DATA_W),
    .NUM_LED      (NUM_LED),
    .ACT_CYCLES   (ACT),
    .BLINK_CYCLES (BLINK),
    .AVG_SHIFT    (AVG_SHIFT)
  ) dut (
    .iCLK  (clk),
    .iRSTN (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_m  = 0;   // filter model state (smoothing build only)
  int lvl_m  = 0;   // level the display should currently reflect
  bit cur_mode = 1'b0;

  // Half-scale: clamp to the DATA_W-1 bit range, then double.
  function automatic int range_map(input int d, input bit rng);
    int c;
    if (rng) return d;
    c = d;
    if (c > 255)  c = 255;
    if (c < -256) c = -256;
    return c * 2;
  endfunction

  function automatic int filt(input int s);
`ifdef LED_SMOOTH_EN
    acc_m = acc_m + s - (acc_m >>> AVG_SHIFT);
    return acc_m >>> AVG_SHIFT;
`else
    return s;
`endif
  endfunction

  // Pattern from positions: LED i sits at 2*i on a doubled axis; the dot
  // is centred at 2L-1+k, and a bar fills from L up to that centre.
  function automatic logic [NUM_LED-1:0] exp_pat(input int lvl, input bit mode);
    int a, k, c, p;
    logic [NUM_LED-1:0] r;
    a = (lvl < 0) ? -lvl - 1 : lvl;
    k = (a * NUM_LED) / (1 << (DATA_W - 1));
    if (k > NUM_LED - 1) k = NUM_LED - 1;
    c = 2 * L - 1 + k;
    r = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      p = (lvl < 0) ? NUM_LED - 1 - i : i;
      if (!mode)       r[i] = (2 * p >= c - 1) && (2 * p <= c + 1);
      else if (k == 0) r[i] = (p == L - 1) || (p == L);
      else             r[i] = (p >= L) && (2 * p <= c + 1);
    end
    return r;
  endfunction

  // Strobe one sample; check the 1-clock view (old sample, new mode) and the 2-clock result.
  task automatic send(input int d, input bit rng, input bit mode, input string nm);
    int old_lvl;
    logic [NUM_LED-1:0] e;
    old_lvl = lvl_m;
    @(negedge clk);
    bus.iDIG       = d[DATA_W-1:0];
    bus.iRANGE     = rng;
    bus.iMODE      = mode;
    bus.iDIG_VALID = 1'b1;
    lvl_m    = filt(range_map(d, rng));
    cur_mode = mode;
    @(negedge clk);
    bus.iDIG_VALID = 1'b0;
    e = exp_pat(old_lvl, mode);
    checks++;
    if (bus.oLED !== e) begin
      errors++;
      $display("FAIL %s_lat1: oLED=%h expected %h", nm, bus.oLED, e);
    end
    @(negedge clk);
    e = exp_pat(lvl_m, mode);
    checks++;
    if (bus.oLED !== e) begin
      errors++;
      $display("FAIL %s: d=%0d rng=%0b mode=%0b oLED=%h expected %h", nm, d, rng, mode, bus.oLED, e);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.oLED !== '0) begin errors++; $display("FAIL reset_led: oLED=%h expected 000", bus.oLED); end
    checks++;
    if (bus.oACTIVE !== 1'b0) begin errors++; $display("FAIL reset_active: oACTIVE=%b expected 0", bus.oACTIVE); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oLED !== exp_pat(0, 1'b0)) begin
      errors++; $display("FAIL post_reset_led: oLED=%h expected %h", bus.oLED, exp_pat(0, 1'b0));
    end
    checks++;
    if (bus.oACTIVE !== 1'b0) begin errors++; $display("FAIL post_reset_active: oACTIVE=%b expected 0", bus.oACTIVE); end
  endtask

  task automatic test_directed();
    int d_t[9]  = '{256, -1, 511, -512, 256, -256, 200, 300, -300};
    bit r_t[9]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit m_t[9]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    logic [NUM_LED-1:0] e_t[9] = '{10'h080, 10'h030, 10'h200, 10'h001, 10'h0E0,
                                   10'h01C, 10'h100, 10'h200, 10'h001};
    for (int i = 0; i < 9; i++) begin
      send(d_t[i], r_t[i], m_t[i], "directed_model");
      checks++;
      if (bus.oLED !== e_t[i]) begin
        errors++;
        $display("FAIL directed_%0d: d=%0d oLED=%h expected %h", i, d_t[i], bus.oLED, e_t[i]);
      end
    end
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 30; i++) begin
      d = int'($urandom_range(1023)) - 512;
      send(d, 1'($urandom_range(1)), 1'($urandom_range(1)), "random");
    end
  endtask

  // Raise iG_INT2, track blink phase with a time-since-trigger model, optionally retrigger.
  task automatic test_activity(input int retrig_at, input string nm);
    int t, wait_n, detect_in, active_n, exp_total, d;
    bit injected, retrigged;
    logic [NUM_LED-1:0] e;
    bus.iG_INT2 = 1'b1;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (bus.oACTIVE !== 1'b1 && wait_n < 10);
    checks++;
    if (wait_n != 3) begin
      errors++; $display("FAIL %s_detect: latency=%0d expected 3", nm, wait_n);
    end
    t = 0; detect_in = 0; active_n = 0; injected = 0; retrigged = 0;
    exp_total = (retrig_at < 0) ? ACT : retrig_at + 3 + ACT;
    while (t < ACT && active_n < 200 && wait_n < 10) begin
      e = (((t / BLINK) % 2) == 0) ? '1 : '0;
      checks++;
      if (bus.oACTIVE !== 1'b1 || bus.oLED !== e) begin
        errors++;
        $display("FAIL %s_blink: t=%0d oACTIVE=%b oLED=%h expected 1 %h", nm, t, bus.oACTIVE, bus.oLED, e);
      end
      active_n++;
      bus.iDIG_VALID = 1'b0;
      if (t == 5 && detect_in == 0) bus.iG_INT2 = 1'b0;
      if (t == 10 && !injected) begin
        injected = 1;
        d = int'($urandom_range(1023)) - 512;
        bus.iDIG = d[DATA_W-1:0];
        bus.iRANGE = 1'b1;
        bus.iDIG_VALID = 1'b1;
        lvl_m = filt(d);
      end
      if (retrig_at >= 0 && t == retrig_at && !retrigged) begin
        retrigged = 1;
        bus.iG_INT2 = 1'b1;
        detect_in = 3;
      end
      @(negedge clk);
      if (detect_in > 0) begin
        detect_in--;
        t = (detect_in == 0) ? 0 : t + 1;
      end else begin
        t++;
      end
    end
    bus.iDIG_VALID = 1'b0;
    bus.iG_INT2 = 1'b0;
    e = exp_pat(lvl_m, cur_mode);
    checks++;
    if (bus.oACTIVE !== 1'b0 || bus.oLED !== e) begin
      errors++;
      $display("FAIL %s_exit: oACTIVE=%b oLED=%h expected 0 %h", nm, bus.oACTIVE, bus.oLED, e);
    end
    checks++;
    if (active_n != exp_total) begin
      errors++; $display("FAIL %s_length: active clocks=%0d expected %0d", nm, active_n, exp_total);
    end
  endtask

  task automatic test_reset_mid();
    bus.iG_INT2 = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.oACTIVE !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: oACTIVE=%b expected 1", bus.oACTIVE); end
    bus.iDIG = 10'sd300;
    bus.iRANGE = 1'b1;
    bus.iDIG_VALID = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.oLED !== '0 || bus.oACTIVE !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: oLED=%h oACTIVE=%b expected 000 0", bus.oLED, bus.oACTIVE);
    end
    @(negedge clk);
    bus.iDIG_VALID = 1'b0;
    bus.iG_INT2 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.oLED !== '0 || bus.oACTIVE !== 1'b0) begin
      errors++; $display("FAIL rst_mid_hold: oLED=%h oACTIVE=%b expected 000 0", bus.oLED, bus.oACTIVE);
    end
    rst_n = 1'b1;
    acc_m = 0;
    lvl_m = 0;
    send(0, 1'b1, 1'b0, "rst_zero_model");
    checks++;
    if (bus.oLED !== 10'h030) begin errors++; $display("FAIL rst_zero: oLED=%h expected 030", bus.oLED); end
  endtask

  task automatic test_smooth();
    int top, prev_top, reached;
    for (int i = 0; i < 4; i++) send(0, 1'b1, 1'b0, "smooth_zero");
    prev_top = 0;
    reached = 0;
    for (int i = 0; i < 20; i++) begin
      send(511, 1'b1, 1'b0, "smooth_step");
      top = -1;
      for (int b = 0; b < NUM_LED; b++) if (bus.oLED[b] === 1'b1) top = b;
      checks++;
      if (top < prev_top) begin
        errors++; $display("FAIL smooth_monotonic: step=%0d top=%0d expected >= %0d", i, top, prev_top);
      end
      prev_top = top;
      if (reached == 0 && bus.oLED === 10'h200) reached = i + 1;
    end
    checks++;
    if (reached == 0) begin errors++; $display("FAIL smooth_reach: oLED=%h expected 200 within 20 strobes", bus.oLED); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iDIG       = '0;
    bus.iDIG_VALID = 1'b0;
    bus.iRANGE     = 1'b1;
    bus.iMODE      = 1'b0;
    bus.iG_INT2    = 1'b0;
    rst_n          = 1'b0;
    test_reset();
`ifndef LED_SMOOTH_EN
    test_directed();
`endif
    test_random();
    send(100, 1'b1, 1'b0, "pre_activity");
    test_activity(-1, "act_single");
    test_activity(38, "act_retrig");
    test_reset_mid();
`ifdef LED_SMOOTH_EN
    test_smooth();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_level_bar.md
Name: led_level_bar

Overview:
Parametrised tilt/level bar driver for the board LED row. It takes signed accelerometer samples, optionally smooths them, and quantises them into a centred dot or bar pattern. A retriggerable activity-blink timer runs from the accelerometer interrupt. It sits between the accelerometer SPI readout and the LED pins, and generalises LED count, sample width, range scaling and display mode.

Parameters:
DATA_W, 10, signed sample width (>=4)
NUM_LED, 10, LED count; even, >=4
ACT_CYCLES, 8388608, clocks the activity display lasts per trigger
BLINK_CYCLES, 1048576, half-period of the activity blink (ACT_CYCLES >= 2*BLINK_CYCLES)
AVG_SHIFT, 2, smoothing shift, 1..4; used only with LED_SMOOTH_EN

Ports:
iCLK  in  1  system clock
iRSTN  in  1  reset, asynchronous, active-low
iDIG  in  DATA_W  signed two's-complement sample
iDIG_VALID  in  1  one-cycle strobe; iDIG is sampled when high
iRANGE  in  1  1 = full scale; 0 = half scale (x2 gain, saturating)
iMODE  in  1  0 = dot pattern; 1 = bar pattern
iG_INT2  in  1  asynchronous activity interrupt, level
oLED  out  NUM_LED  LED drive, 1 = on
oACTIVE  out  1  high while the ACTIVITY state is active

Behaviour:
- Reset (iRSTN low, async): oLED=0, oACTIVE=0, sample/filter regs=0, sync flops=0, state=DISPLAY, counter=0.
- Range: iRANGE=1 -> s=iDIG. iRANGE=0 -> saturate iDIG to DATA_W-1 bits, then shift left by 1 (s in -2^(DATA_W-1)..2^(DATA_W-1)-2). iRANGE is sampled with iDIG_VALID.
- Sample reg: loads s on the cycle after iDIG_VALID; holds otherwise.
- Level: a = s<0 ? ~s : s (one's-complement magnitude, DATA_W-1 bits). k = min((a*NUM_LED) >> (DATA_W-1), NUM_LED-1). L = NUM_LED/2.
- Dot, positive: lit indices lo..hi, where lo = L-1+ceil(k/2) and hi = L+floor(k/2). Negative: mirror, i -> NUM_LED-1-i.
- Bar, positive: k=0 lights {L-1,L}; k>0 lights L..hi. Negative: mirror.
- oLED registered; latency iDIG_VALID -> oLED = 2 clocks in DISPLAY. iMODE is applied combinationally into that register (1-clock effect).
- Activity: iG_INT2 passes a 2-flop synchroniser plus an edge register. A rising edge is detected on the 3rd clock after the rise.
- States DISPLAY and ACTIVITY.
  - DISPLAY -> ACTIVITY on a detected edge: counter cleared.
  - ACTIVITY: counter increments each clock. oLED = all-ones when (counter/BLINK_CYCLES) is even, all-zeros otherwise.
  - ACTIVITY -> DISPLAY when counter = ACT_CYCLES-1.
  - An edge during ACTIVITY restarts the counter at 0 (retrigger).
- oACTIVE is registered and equals (state==ACTIVITY).
- Samples keep updating during ACTIVITY. The first oLED after return to DISPLAY reflects the latest sample.
- Simultaneous edge and counter terminal: the edge wins; stay in ACTIVITY with counter=0.
- Counter width = clog2(ACT_CYCLES). No wrap is possible.

Optional Feature:
LED_SMOOTH_EN
- Defined: filter acc (DATA_W+AVG_SHIFT bits, signed) updates on each loaded sample: acc <= acc + s - (acc>>>AVG_SHIFT). The level path uses acc>>>AVG_SHIFT. acc resets to 0. Latency stays 2 clocks (the filter replaces the sample reg).
- Undefined: the level path uses the sample reg directly; AVG_SHIFT is ignored.

Decomposition:
- Package led_bar_pkg: state enum {DISPLAY, ACTIVITY}; clog2 helper; function computing k from magnitude.
- Sub-module led_bar_encode: combinational, takes (k, sign, mode) and returns the NUM_LED pattern. It is instanced once before the oLED register.

Test Plan:
Defaults, iRANGE=1, iMODE=0, no activity:
- Samples +256, -1, +511, -512 -> oLED 0x080, 0x030, 0x200, 0x001, each 2 clocks after its strobe.
- iMODE=1 with +256 -> 0x0E0. With -256 -> 0x01C.
- iRANGE=0 with +200 -> 0x100. With +300 (saturates to 510) -> 0x200. With -300 -> 0x001.
- ACT_CYCLES=64, BLINK_CYCLES=8, iG_INT2 rising:
  - oACTIVE rises, oLED=0x3FF for 8 clocks, then 0x000 for 8, repeating.
  - Exactly 64 ACTIVITY clocks, then oLED shows the latest sample.
  - A second iG_INT2 rise at counter 40 extends ACTIVITY to 64 clocks from the new edge.
- Assert iRSTN low mid-ACTIVITY and mid-sample -> oLED=0 and oACTIVE=0 immediately (async). After release and one sample of 0 -> oLED=0x030.
- With LED_SMOOTH_EN, AVG_SHIFT=2: step 0 -> +511 -> oLED moves monotonically outward over successive strobes and reaches 0x200 within 20 strobes.
